host_uart_command_dec: RTL

- Host-side command decoder; the receive-path counterpart of the host UART response encoder.
- Accepts a byte stream from the UART RX path and frames it into commands: 1 ID byte, 6 reserved bytes, then an ID-specific payload.
- Presents a decoded cmd_select/cmd_data pair to the command handler and holds it until acknowledged.
- cmd_select values match the encoder's select codes, so the handler can route each response directly.

---
 rtl/host_uart_command_dec.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/host_uart_command_dec.sv
// Host command decoder: frames UART RX bytes into ID, 6 reserved bytes and payload.
// The decoded command is held for the handler until it is acknowledged.
module host_uart_command_dec #(
   parameter logic [7:0]  ENCRYPT_ENABLE_CMD_ID = 8'h01,
   parameter logic [7:0]  READ_YAW_CMD_ID       = 8'h03,
   parameter logic [7:0]  SET_KEY_CMD_ID        = 8'h05,
   parameter int unsigned TIMEOUT_CYCLES        = 100000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic         cmd_valid,
   input  logic         cmd_ack,
   output logic [15:0]  cmd_select,
   output logic [263:0] cmd_data,
   output logic         error,
   output logic [1:0]   err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_HOLD
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [5:0]    len;
   logic [5:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          acc;
   logic          tmo_hit;
   logic          id_known;
   logic [15:0]   id_sel;
   logic [5:0]    id_len;
   logic          rdy_nxt;
   logic          vld_nxt;
   logic [8:0]    wr_idx;

   assign acc     = rx_valid && rx_ready;
   assign tmo_hit = (state == S_HEADER || state == S_PAYLOAD)
                    && tmo_cnt == TMO_LAST;
   assign wr_idx  = {byte_cnt[4:0], 3'b000};

   always_comb begin
      id_known = 1'b0;
      id_sel   = 16'h0;
      id_len   = 6'd0;
      unique case (1'b1)
         (rx_data == ENCRYPT_ENABLE_CMD_ID): begin
            id_known = 1'b1;
            id_sel   = 16'h1;
            id_len   = 6'd1;
         end
         (rx_data == READ_YAW_CMD_ID): begin
            id_known = 1'b1;
            id_sel   = 16'h2;
            id_len   = 6'd0;
         end
         (rx_data == SET_KEY_CMD_ID): begin
            id_known = 1'b1;
            id_sel   = 16'h3;
            id_len   = 6'd32;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         rx_ready  <= 1'b0;
         cmd_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rx_ready  <= rdy_nxt;
         cmd_valid <= vld_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (acc && id_known)
               state_nxt = S_HEADER;
         end
         S_HEADER: begin
            if (tmo_hit)
               state_nxt = S_IDLE;
            else if (acc) begin
               if (rx_data != 8'h00)
                  state_nxt = S_IDLE;
               else if (byte_cnt == 6'd5)
                  state_nxt = (len != 6'd0) ? S_PAYLOAD : S_HOLD;
            end
         end
         S_PAYLOAD: begin
            if (tmo_hit)
               state_nxt = S_IDLE;
            else if (acc && byte_cnt == len - 6'd1)
               state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (cmd_ack && cmd_valid)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // valid is registered one cycle behind HOLD entry; ack only counts once seen
   always_comb begin
      rdy_nxt = (state_nxt != S_HOLD);
      vld_nxt = (state == S_HOLD) && !(cmd_ack && cmd_valid);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_select <= 16'h0;
         cmd_data   <= '0;
         len        <= 6'd0;
         byte_cnt   <= 6'd0;
         error      <= 1'b0;
         err_code   <= 2'd0;
      end else begin
         error <= 1'b0;
         if (tmo_hit) begin
            error    <= 1'b1;
            err_code <= 2'd3;
         end else if (acc) begin
            unique case (state)
               S_IDLE: begin
                  cmd_data <= '0;
                  if (id_known) begin
                     cmd_select <= id_sel;
                     len        <= id_len;
                     byte_cnt   <= 6'd0;
                  end else begin
                     error    <= 1'b1;
                     err_code <= 2'd1;
                  end
               end
               S_HEADER: begin
                  if (rx_data != 8'h00) begin
                     error    <= 1'b1;
                     err_code <= 2'd2;
                  end else if (byte_cnt == 6'd5)
                     byte_cnt <= 6'd0;
                  else
                     byte_cnt <= byte_cnt + 6'd1;
               end
               S_PAYLOAD: begin
                  cmd_data[wr_idx +: 8] <= rx_data;
                  byte_cnt              <= byte_cnt + 6'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         tmo_cnt <= '0;
      else if (state == S_IDLE || state == S_HOLD || acc || tmo_hit)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

endmodule
